// File: rtl/mem_bus_if.sv
// Strobe/acknowledge bus between the transfer controller and external memory.
// The controller is the master and the memory is the slave.
interface mem_bus_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_xfer_ctrl.sv
// Single-request memory transfer controller with a bounded acknowledge wait.
// Completed reads drive the MDR register stage through mdr_d/mdr_en.
module mem_xfer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] mdr_d,
    output logic                  mdr_en,
    mem_bus_if.master             mem
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT, DONE, ERR} state_t;

    state_t           state;
    logic             op_wr;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here is written with <= so all of them update
    // together from the values sampled at the same clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op_wr         <= 1'b0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            mdr_en        <= 1'b0;
            mdr_d         <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_rd    <= 1'b0;
            mem.mem_wr    <= 1'b0;
        end else begin
            // Pulses default low and are raised only on the entering edge.
            done   <= 1'b0;
            err    <= 1'b0;
            mdr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        mem.mem_addr  <= addr;
                        mem.mem_wdata <= wdata;
                        op_wr         <= wr;
                        busy          <= 1'b1;
                        state         <= SETUP;
                    end
                end

                SETUP: begin
                    cnt        <= '0;
                    mem.mem_rd <= ~op_wr;
                    mem.mem_wr <= op_wr;
                    state      <= WAIT;
                end

                WAIT: begin
                    if (mem.mem_ack) begin
                        mem.mem_rd <= 1'b0;
                        mem.mem_wr <= 1'b0;
                        done       <= 1'b1;
                        if (!op_wr) begin
                            mdr_d  <= mem.mem_rdata;
                            mdr_en <= 1'b1;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem.mem_rd <= 1'b0;
                        mem.mem_wr <= 1'b0;
                        err        <= 1'b1;
                        state      <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    mem.mem_rd <= 1'b0;
                    mem.mem_wr <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl: directed scenarios plus random
// transfers, compared against a cycle-count model of each transaction.
module tb_mem_xfer_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int T  = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy, done, err, mdr_en;
    logic [DW-1:0] mdr_d;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] model_mdr = '0;

    mem_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem ();

    mem_xfer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .mdr_d  (mdr_d),
        .mdr_en (mdr_en),
        .mem    (mem.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},   32'(busy),          0);
        check({tag, " done"},   32'(done),          0);
        check({tag, " err"},    32'(err),           0);
        check({tag, " mdr_en"}, 32'(mdr_en),        0);
        check({tag, " mdr_d"},  32'(mdr_d),         0);
        check({tag, " rd"},     32'(mem.mem_rd),    0);
        check({tag, " wr"},     32'(mem.mem_wr),    0);
        check({tag, " addr"},   32'(mem.mem_addr),  0);
        check({tag, " wdata"},  32'(mem.mem_wdata), 0);
    endtask

    // One request. ack_k is the WAIT cycle (1-based) on which memory acks;
    // values outside 1..T mean memory never acks. Cycle c counts edges after
    // the edge that samples start: WAIT spans cycles 2..n+1, DONE/ERR is n+2.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int ack_k, input logic [DW-1:0] rv, input bit noise);
        bit ok;
        int n;
        ok = (ack_k >= 1 && ack_k <= T);
        n  = ok ? ack_k : T;
        @(negedge clk);
        start = 1'b1; wr = w; addr = a; wdata = d; mem.mem_ack = 1'b0;
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (c == n + 2 && ok && !w) model_mdr = rv;
            check("busy",   32'(busy),   32'(c <= n + 2));
            check("rd",     32'(mem.mem_rd), 32'(!w && c >= 2 && c <= n + 1));
            check("wr",     32'(mem.mem_wr), 32'(w && c >= 2 && c <= n + 1));
            check("done",   32'(done),   32'(ok && c == n + 2));
            check("err",    32'(err),    32'(!ok && c == n + 2));
            check("mdr_en", 32'(mdr_en), 32'(ok && !w && c == n + 2));
            check("mdr_d",  32'(mdr_d),  32'(model_mdr));
            check("mem_addr",  32'(mem.mem_addr),  32'(a));
            check("mem_wdata", 32'(mem.mem_wdata), 32'(d));
            // Drive inputs for the next edge; requests while busy must be ignored.
            start = noise && (c <= n + 2) && ($urandom_range(1, 0) == 1);
            addr  = noise ? 8'hFF : a;
            wr    = noise ? 1'($urandom_range(1, 0)) : w;
            wdata = noise ? DW'($urandom) : d;
            mem.mem_rdata = (c == n + 1) ? rv : DW'($urandom);
            if (ok && c == n + 1)      mem.mem_ack = 1'b1;
            else if (c == 1 || c == n + 2) mem.mem_ack = 1'($urandom_range(1, 0));
            else                       mem.mem_ack = 1'b0;
        end
        start = 1'b0; mem.mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; wr = 1'b0; addr = 8'h12; wdata = 8'h34;
        mem.mem_ack = 1'b1; mem.mem_rdata = 8'hEE;

        // Reset with a concurrent start: reset wins.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0; start = 1'b0; mem.mem_ack = 1'b0;
        @(negedge clk);
        check("lost_req busy", 32'(busy), 0);

        // Directed scenarios.
        xfer(1'b0, 8'h3C, 8'h00, 1,  8'hA5, 1'b0);  // read, zero-wait
        xfer(1'b1, 8'h10, 8'h5A, 5,  8'h00, 1'b0);  // write, 4 wait states
        xfer(1'b0, 8'h21, 8'h00, 0,  8'h99, 1'b0);  // timeout, mdr_d kept
        xfer(1'b0, 8'h42, 8'h00, T,  8'hC3, 1'b0);  // ack on last WAIT cycle
        xfer(1'b1, 8'h55, 8'h66, 6,  8'h00, 1'b1);  // busy lockout noise

        // Reset during WAIT, then a late ack that must be ignored.
        @(negedge clk);
        start = 1'b1; wr = 1'b0; addr = 8'h77;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        check("midwait rd", 32'(mem.mem_rd), 1);
        rst = 1'b1;
        @(negedge clk);
        model_mdr = '0;
        check_all_zero("midreset");
        rst = 1'b0; mem.mem_ack = 1'b1; mem.mem_rdata = 8'hBB;
        repeat (3) begin
            @(negedge clk);
            check("post_rst busy",   32'(busy),   0);
            check("post_rst done",   32'(done),   0);
            check("post_rst mdr_en", 32'(mdr_en), 0);
            check("post_rst mdr_d",  32'(mdr_d),  0);
        end
        mem.mem_ack = 1'b0;
        xfer(1'b0, 8'h88, 8'h00, 2, 8'h3E, 1'b0);

        // Random transfers, including timeouts and lockout noise.
        for (int i = 0; i < 25; i++) begin
            xfer(1'($urandom_range(1, 0)), AW'($urandom), DW'($urandom),
                 $urandom_range(T + 2, 0), DW'($urandom), 1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
